// File: rtl/serial_frame_ctrl.sv
// serial_frame_ctrl
// Button-stepped serial frame sequencer. Each single-cycle clk_en consumes one
// serial bit. In HUNT the block looks for HEADER (the first bit received is
// compared against HEADER[3]). In LEN it reads a 4-bit length L, MSB first.
// In PAYLOAD it forwards L+1 bits to ser_out, each with a one-clk valid strobe.
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous reset, active low
//   clk_en        step pulse; a serial bit is consumed only when this is 1
//   ser_in        serial data, sampled only when clk_en=1
//   abort         synchronous return to HUNT; wins over clk_en
//   ser_out       last forwarded payload bit (holds between strobes)
//   ser_out_valid one-clk pulse per forwarded payload bit
//   frame_done    one-clk pulse together with the final payload strobe
//   busy          state != HUNT
//   cnt           remaining payload bits minus 1 (hex display)
//   state_dbg     HUNT=0, LEN=1, PAYLOAD=2
module serial_frame_ctrl #(
  parameter logic [3:0] HEADER = 4'b1011
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic       ser_in,
  input  logic       abort,
  output logic       ser_out,
  output logic       ser_out_valid,
  output logic       frame_done,
  output logic       busy,
  output logic [3:0] cnt,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    LEN     = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

  state_t     state, nxt;
  logic [3:0] win;
  logic [2:0] fill;
  logic [3:0] len_sh;
  logic [1:0] len_idx;

  logic [3:0] win_nxt;
  logic       hit;

  // The window including the incoming bit; fill>=3 means the incoming bit is
  // at least the 4th since HUNT entry, so stale zeros never form a header.
  assign win_nxt = {win[2:0], ser_in};
  assign hit     = (win_nxt == HEADER) && (fill >= 3'd3);

  assign busy      = (state != HUNT);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= HUNT;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (abort) begin
      nxt = HUNT;
    end else if (clk_en) begin
      case (state)
        HUNT:    if (hit) nxt = LEN;
        LEN:     if (len_idx == 2'd3) nxt = PAYLOAD;
        PAYLOAD: if (cnt == 4'd0) nxt = HUNT;
        default: nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win           <= 4'd0;
      fill          <= 3'd0;
      len_sh        <= 4'd0;
      len_idx       <= 2'd0;
      cnt           <= 4'd0;
      ser_out       <= 1'b0;
      ser_out_valid <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      ser_out_valid <= 1'b0;
      frame_done    <= 1'b0;
      if (abort) begin
        // Bit presented alongside abort is dropped; no strobes this cycle.
        win     <= 4'd0;
        fill    <= 3'd0;
        len_idx <= 2'd0;
        cnt     <= 4'd0;
      end else if (clk_en) begin
        case (state)
          HUNT: begin
            win <= win_nxt;
            if (fill != 3'd4) fill <= fill + 3'd1;
            if (hit) len_idx <= 2'd0;
          end
          LEN: begin
            len_sh  <= {len_sh[2:0], ser_in};
            len_idx <= len_idx + 2'd1;
            if (len_idx == 2'd3) cnt <= {len_sh[2:0], ser_in};
          end
          PAYLOAD: begin
            ser_out       <= ser_in;
            ser_out_valid <= 1'b1;
            if (cnt != 4'd0) begin
              cnt <= cnt - 4'd1;
            end else begin
              // Last bit: restart the hunt from an empty window so header
              // bits never carry across frames.
              frame_done <= 1'b1;
              win        <= 4'd0;
              fill       <= 3'd0;
            end
          end
          default: begin
            win  <= 4'd0;
            fill <= 3'd0;
          end
        endcase
      end
    end
  end

endmodule
